// File: rtl/ysyx_22041071_div_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_22041071_div_ctrl
//
// EXE-stage front end for the iterative divider. Takes RV64M DIV/DIVU/REM/REMU
// requests (and their W forms). Divide-by-zero and signed overflow are answered
// locally in one cycle. Every other request is handed to the divider, and the
// quotient or remainder it returns is captured. W results are sign-extended
// from bit 31. The captured result is held until the pipeline takes it.
//
// Handshakes (all of them): a transfer happens on a rising clk edge where the
// producer's valid and the consumer's ready are both high. req_*: EXE ->
// controller. res_*: controller -> pipeline. div_valid/div_ready: controller ->
// divider. out_valid is a one-cycle strobe from the divider and has no ready.
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   flush             kills the in-flight op; highest priority after reset
//   req_valid/ready   request handshake; req_op 00 DIV 01 DIVU 10 REM 11 REMU
//   req_w             32-bit (W) form
//   src1, src2        dividend / divisor
//   res_valid/ready   result handshake; result = final rd value (registered)
//   div_valid         operands valid to the divider (WAIT only)
//   div_signed, divw  divider sign / width controls
//   dividend, divisor operands to the divider
//   div_flush         cancel to the divider (flush while in WAIT)
//   div_ready         divider idle
//   out_valid         divider quot/rema valid this cycle
//   quot, rema        divider results
//   state_dbg         FSM state: 0 IDLE, 1 WAIT, 2 HOLD
// ----------------------------------------------------------------------------
module ysyx_22041071_div_ctrl #(
    parameter int XLEN       = 64,
    parameter bit BYPASS_SPC = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic            req_w,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] result,
    output logic            div_valid,
    output logic            div_signed,
    output logic            divw,
    output logic [XLEN-1:0] dividend,
    output logic [XLEN-1:0] divisor,
    output logic            div_flush,
    input  logic            div_ready,
    input  logic            out_valid,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] rema,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_nxt;
    logic [1:0]      op_q;
    logic            w_q;
    logic            sgn_q;
    logic [XLEN-1:0] src1_q, src2_q;
    logic [XLEN-1:0] result_q;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    // Special-case detection on the incoming request. DIV/REM are the signed
    // ops (op[0] == 0).
    logic            req_signed;
    logic            is_zero, is_ovf, special;
    logic [XLEN-1:0] spc_q, spc_r, spc_sel, spc_res;

    assign req_signed = ~req_op[0];
    assign is_zero    = req_w ? (src2[31:0] == 32'h0) : (src2 == '0);
    assign is_ovf     = req_signed &
                        (req_w ? ((src1[31:0] == 32'h8000_0000) && (src2[31:0] == 32'hFFFF_FFFF))
                               : ((src1 == MIN_INT) && (src2 == '1)));
    assign special    = BYPASS_SPC & (is_zero | is_ovf);

    // Zero divisor takes priority: quot = all-ones, rem = dividend.
    // Overflow: quot = dividend, rem = 0.
    assign spc_q   = is_zero ? '1   : src1;
    assign spc_r   = is_zero ? src1 : '0;
    assign spc_sel = req_op[1] ? spc_r : spc_q;
    assign spc_res = req_w ? sext32(spc_sel) : spc_sel;

    logic [XLEN-1:0] div_sel, div_res;
    assign div_sel = op_q[1] ? rema : quot;
    assign div_res = w_q ? sext32(div_sel) : div_sel;

    // No accept in the flush cycle; req_ready already excludes WAIT/HOLD.
    logic accept;
    assign accept = req_valid & req_ready & ~flush;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            op_q     <= 2'b00;
            w_q      <= 1'b0;
            sgn_q    <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q   <= req_op;
                w_q    <= req_w;
                sgn_q  <= req_signed;
                src1_q <= src1;
                src2_q <= src2;
            end
            if (accept && special) begin
                result_q <= spc_res;
            end else if ((state == S_WAIT) && out_valid && !flush) begin
                result_q <= div_res;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        div_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = special ? S_HOLD : S_WAIT;
            end
            S_WAIT: begin
                // Held high through the out_valid cycle; dropping it in HOLD
                // keeps the divider from restarting.
                div_valid = 1'b1;
                if (out_valid) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Flush discards any pending or just-arriving result.
        if (flush) state_nxt = S_IDLE;
    end

    // Operand and sign controls come straight from the latched registers so
    // they stay stable for the whole WAIT period, out_valid cycle included.
    assign req_ready  = (state == S_IDLE) & div_ready;
    assign res_valid  = (state == S_HOLD);
    assign result     = result_q;
    assign dividend   = src1_q;
    assign divisor    = src2_q;
    assign div_signed = sgn_q;
    assign divw       = w_q;
    assign div_flush  = flush & (state == S_WAIT);
    assign state_dbg  = state;

endmodule

// File: tb/tb_ysyx_22041071_div_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for ysyx_22041071_div_ctrl: a behavioural divider model, directed
// vectors for the special cases, hold/flush/reset sequences and randomized
// requests checked against an RV64M reference model through an expected queue.
// ----------------------------------------------------------------------------
module tb_ysyx_22041071_div_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic        req_w = 1'b0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [63:0] result;
    logic        div_valid, div_signed, divw, div_flush;
    logic [63:0] dividend, divisor;
    logic        div_ready;
    logic        out_valid = 1'b0;
    logic [63:0] quot = '0;
    logic [63:0] rema = '0;
    logic [1:0]  state_dbg;

    ysyx_22041071_div_ctrl #(.XLEN(64), .BYPASS_SPC(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_w(req_w),
        .src1(src1), .src2(src2),
        .res_valid(res_valid), .res_ready(res_ready), .result(result),
        .div_valid(div_valid), .div_signed(div_signed), .divw(divw),
        .dividend(dividend), .divisor(divisor), .div_flush(div_flush),
        .div_ready(div_ready), .out_valid(out_valid), .quot(quot), .rema(rema),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    // ---------------- reference model (RV64M semantics) ----------------
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic               sgn;
        logic signed [31:0] sa32, sb32;
        logic signed [63:0] sa64, sb64;
        logic [31:0]        q32, r32, s32;
        logic [63:0]        q64, r64;
        sgn = ~op[0];
        if (w) begin
            sa32 = a[31:0];
            sb32 = b[31:0];
            if (b[31:0] == 32'h0) begin
                q32 = 32'hFFFF_FFFF; r32 = a[31:0];
            end else if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                q32 = a[31:0]; r32 = 32'h0;
            end else if (sgn) begin
                q32 = sa32 / sb32; r32 = sa32 % sb32;
            end else begin
                q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
            end
            s32 = op[1] ? r32 : q32;
            return {{32{s32[31]}}, s32};
        end
        sa64 = a;
        sb64 = b;
        if (b == 64'h0) begin
            q64 = '1; r64 = a;
        end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q64 = a; r64 = '0;
        end else if (sgn) begin
            q64 = sa64 / sb64; r64 = sa64 % sb64;
        end else begin
            q64 = a / b; r64 = a % b;
        end
        return op[1] ? r64 : q64;
    endfunction

    // ---------------- behavioural divider ----------------
    // Returns W results with random upper bits so the controller's
    // sign-extension is exercised.
    function automatic logic [63:0] div_calc(input logic [63:0] a, input logic [63:0] b,
                                             input logic s, input logic w, input logic rem);
        logic signed [31:0] sa32, sb32;
        logic signed [63:0] sa64, sb64;
        logic [31:0]        q32, r32;
        logic [63:0]        q64, r64;
        if (w) begin
            sa32 = a[31:0]; sb32 = b[31:0];
            if (b[31:0] == 32'h0) begin q32 = '1; r32 = a[31:0]; end
            else if (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin q32 = a[31:0]; r32 = '0; end
            else if (s) begin q32 = sa32 / sb32; r32 = sa32 % sb32; end
            else begin q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0]; end
            return {$urandom(), rem ? r32 : q32};
        end
        sa64 = a; sb64 = b;
        if (b == 64'h0) begin q64 = '1; r64 = a; end
        else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin q64 = a; r64 = '0; end
        else if (s) begin q64 = sa64 / sb64; r64 = sa64 % sb64; end
        else begin q64 = a / b; r64 = a % b; end
        return rem ? r64 : q64;
    endfunction

    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    int          div_lat = 4;
    int          starts = 0;
    logic [63:0] m_a = '0, m_b = '0;
    logic        m_s = 1'b0, m_w = 1'b0;

    assign div_ready = ~m_busy;

    always @(posedge clk) begin
        if (!reset) begin
            m_busy    <= 1'b0;
            out_valid <= 1'b0;
            m_cnt     <= 0;
        end else if (div_flush) begin
            m_busy    <= 1'b0;
            out_valid <= 1'b0;
        end else if (out_valid) begin
            m_busy    <= 1'b0;
            out_valid <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt <= 1) begin
                out_valid <= 1'b1;
                quot      <= div_calc(m_a, m_b, m_s, m_w, 1'b0);
                rema      <= div_calc(m_a, m_b, m_s, m_w, 1'b1);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (div_valid) begin
            m_busy <= 1'b1;
            m_cnt  <= div_lat;
            m_a    <= dividend;
            m_b    <= divisor;
            m_s    <= div_signed;
            m_w    <= divw;
            starts <= starts + 1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          rr_mode = 1'b0;
    logic        rr_fixed = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        res_ready = rr_mode ? 1'($urandom_range(0, 1)) : rr_fixed;
    endtask

    // Drive one request; returns one step after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic push, input logic [63:0] exp);
        int n;
        req_op = op; req_w = w; src1 = a; src2 = b; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 500) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        if (push) exp_q.push_back(exp);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_res_valid();
        int n;
        n = 0;
        while (!res_valid && n < 300) begin
            tick();
            n++;
        end
        chk("res_valid_timeout", 64'(res_valid), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset && out_valid) begin
                chk("div_valid_at_out_valid", 64'(div_valid), 64'd1);
                chk("operands_stable", {dividend ^ m_a} | {divisor ^ m_b} | 64'({div_signed, divw} ^ {m_s, m_w}), 64'd0);
            end
            if (reset && res_valid && res_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", result, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    chk("result", result, exp_q.pop_front());
                end
            end
        end
    endtask

    // ---------------- main sequence ----------------
    task automatic run_tests();
        int          s0;
        logic [63:0] held;
        logic [1:0]  op;
        logic        w;
        logic [63:0] a, b;
        int          sel;

        // Reset
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_div_valid", 64'(div_valid), 64'd0);
        chk("rst_state", 64'(state_dbg), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        // Divider-path W ops
        div_lat = 6;
        issue(2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);

        // Divide by zero: local answer, one-cycle latency, divider untouched
        drain();
        s0 = starts;
        issue(2'b01, 1'b0, 64'h1234, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("divu0_latency", 64'(res_valid), 64'd1);
        chk("divu0_div_valid", 64'(div_valid), 64'd0);
        issue(2'b11, 1'b0, 64'h1234, 64'h0, 1'b1, 64'h1234);
        chk("remu0_latency", 64'(res_valid), 64'd1);

        // Signed overflow
        issue(2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000);
        chk("ovf_latency", 64'(res_valid), 64'd1);
        issue(2'b10, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0);
        drain();
        chk("special_no_div_start", 64'(starts - s0), 64'd0);

        // DIVUW sign-extends the 32-bit quotient
        issue(2'b01, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();

        // Result held while the pipeline stalls
        rr_fixed = 1'b0;
        res_ready = 1'b0;
        issue(2'b00, 1'b0, 64'd100, 64'd7, 1'b1, 64'd14);
        wait_res_valid();
        held = result;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_result", result, 64'd14);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        rr_fixed = 1'b1;
        res_ready = 1'b1;
        tick();
        chk("release_idle", 64'(state_dbg), 64'd0);
        chk("release_req_ready", 64'(req_ready), 64'd1);
        issue(2'b10, 1'b0, 64'd100, 64'd7, 1'b1, 64'd2);
        drain();

        // Flush 20 cycles into WAIT
        div_lat = 40;
        issue(2'b00, 1'b0, 64'd1000, 64'd3, 1'b0, 64'd0);
        repeat (20) tick();
        chk("flush_pre_state", 64'(state_dbg), 64'd1);
        flush = 1'b1;
        #1;
        chk("div_flush_pulse", 64'(div_flush), 64'd1);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_idle", 64'(state_dbg), 64'd0);
        chk("flush_res_valid", 64'(res_valid), 64'd0);
        chk("flush_div_flush_low", 64'(div_flush), 64'd0);
        repeat (50) tick();

        // Request coinciding with flush is not accepted
        req_op = 2'b01; req_w = 1'b0; src1 = 64'h55; src2 = 64'h0;
        req_valid = 1'b1;
        flush = 1'b1;
        tick();
        req_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("flush_req_not_accepted", 64'(state_dbg), 64'd0);
        chk("flush_req_no_result", 64'(res_valid), 64'd0);

        // Reset mid-WAIT
        issue(2'b00, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h11, 1'b0, 64'd0);
        repeat (10) tick();
        reset = 1'b0;
        tick();
        chk("midrst_res_valid", 64'(res_valid), 64'd0);
        chk("midrst_div_valid", 64'(div_valid), 64'd0);
        chk("midrst_outputs", dividend | divisor | result | 64'({div_signed, divw, div_flush}), 64'd0);
        reset = 1'b1;
        tick();

        // Randomized requests with random backpressure
        rr_mode = 1'b1;
        for (int i = 0; i < 60; i++) begin
            op  = 2'($urandom_range(0, 3));
            w   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            if (sel == 0) begin
                b = w ? {$urandom(), 32'h0} : 64'h0;
            end else if (sel == 1) begin
                a = w ? {$urandom(), 32'h8000_0000} : 64'h8000_0000_0000_0000;
                b = w ? {$urandom(), 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
            end else if (sel == 2) begin
                a = 64'($urandom_range(0, 200));
                b = 64'($urandom_range(1, 15));
                if ($urandom_range(0, 1) == 1) a = -a;
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            div_lat = $urandom_range(1, 12);
            issue(op, w, a, b, 1'b1, ref_model(op, w, a, b));
        end
        rr_mode = 1'b0;
        rr_fixed = 1'b1;
        drain();
        repeat (5) tick();
    endtask

    initial begin
        fork
            monitor();
            run_tests();
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
